popcount_neuron_seq: RTL and testbench

Sequencer that evaluates one ternary neuron by time-multiplexing a single 9-input popcount unit over a wide input vector. Each transaction carries a positive mask, a negative mask and a threshold. The block streams both masks through the popcount unit in 9-bit chunks, accumulates the two counts, and produces sum = P − N and a fire bit (sum ≥ threshold). It sits between the sensor-side input register and the layer output buffer, and lets one approximate popcount core serve an arbitrary fan-in.

---
 rtl/popseq_pkg.sv | 23 ++
 rtl/popcount09_unit.sv | 38 +++
 rtl/popcount_neuron_seq.sv | 179 +++++++++++++++++
 tb/tb_popcount_neuron_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/popseq_pkg.sv
// Shared types, constants and sizing helpers for the chunked popcount neuron sequencer.
package popseq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CHUNK_W       = 9;
    localparam int MAX_CHUNK_CNT = 15;

    function automatic int nchunks(input int n_in);
        return (n_in + CHUNK_W - 1) / CHUNK_W;
    endfunction

    // The approximate unit may report up to MAX_CHUNK_CNT per chunk.
    function automatic int acc_width(input int nch);
        return $clog2(MAX_CHUNK_CNT * nch + 1);
    endfunction

endpackage

// File: rtl/popcount09_unit.sv
// Combinational 9-input popcount; USE_EXACT picks an exact count or a cheaper approximate core.
module popcount09_unit #(
    parameter int USE_EXACT = 0
) (
    input  logic [8:0] i_bits,
    output logic [3:0] o_count
);

    generate
        if (USE_EXACT != 0) begin : g_exact
            logic [3:0] w_cnt;
            always_comb begin
                w_cnt = '0;
                for (int i = 0; i < 9; i++) begin
                    w_cnt = w_cnt + 4'(i_bits[i]);
                end
            end
            assign o_count = w_cnt;
        end else begin : g_approx
            // Three exact full adders; their sum bits are merged with an OR instead
            // of a second adder level, so the result can under-count.
            logic [2:0] w_s;
            logic [2:0] w_c;
            logic [1:0] w_ccnt;
            for (genvar gi = 0; gi < 3; gi++) begin : g_fa
                logic w_a, w_b, w_d;
                assign w_a     = i_bits[3*gi];
                assign w_b     = i_bits[3*gi+1];
                assign w_d     = i_bits[3*gi+2];
                assign w_s[gi] = w_a ^ w_b ^ w_d;
                assign w_c[gi] = (w_a & w_b) | (w_a & w_d) | (w_b & w_d);
            end
            assign w_ccnt  = {1'b0, w_c[0]} + {1'b0, w_c[1]} + {1'b0, w_c[2]};
            assign o_count = {1'b0, w_ccnt, |w_s};
        end
    endgenerate

endmodule

// File: rtl/popcount_neuron_seq.sv
// Ternary neuron sequencer: streams both masks through one popcount unit, 9 bits per cycle.
// Define POPSEQ_ZERO_SKIP_EN to skip all-zero chunks within each phase.
module popcount_neuron_seq
    import popseq_pkg::*;
#(
    parameter int N_IN      = 36,
    parameter int THR_W     = 8,
    parameter int USE_EXACT = 0,
    localparam int ACC_W    = acc_width(nchunks(N_IN))
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_IN-1:0]    pos_mask,
    input  logic [N_IN-1:0]    neg_mask,
    input  logic [THR_W-1:0]   threshold,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W:0]     sum,
    output logic               neuron_out,
    output logic               busy
);

    localparam int NCH   = nchunks(N_IN);
    localparam int PAD_W = NCH * CHUNK_W;
    localparam int K_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CMP_W = ((ACC_W + 1 > THR_W) ? ACC_W + 1 : THR_W) + 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NCH - 1);

    state_t               r_state, w_state_next;
    logic [PAD_W-1:0]     r_pos, r_neg;
    logic [THR_W-1:0]     r_thr;
    logic [ACC_W-1:0]     r_acc_p, r_acc_n;
    logic [K_W-1:0]       r_k;
    logic [ACC_W:0]       r_sum;
    logic                 r_fire;

    logic [CHUNK_W-1:0]   w_pos_ch [NCH];
    logic [CHUNK_W-1:0]   w_neg_ch [NCH];
    logic [CHUNK_W-1:0]   w_chunk;
    logic [3:0]           w_count;
    logic [ACC_W-1:0]     w_acc_add;
    logic [ACC_W:0]       w_sum_next;
    logic [CMP_W-1:0]     w_sum_ext, w_thr_ext;
    logic                 w_fire_next;
    logic                 w_has_next, w_last;
    logic [K_W-1:0]       w_k_next, w_first_pos, w_first_neg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chunks
            assign w_pos_ch[gi] = r_pos[gi*CHUNK_W +: CHUNK_W];
            assign w_neg_ch[gi] = r_neg[gi*CHUNK_W +: CHUNK_W];
        end
    endgenerate

    assign w_chunk = (r_state == NEG) ? w_neg_ch[r_k] : w_pos_ch[r_k];

    popcount09_unit #(
        .USE_EXACT (USE_EXACT)
    ) u_popcount (
        .i_bits  (w_chunk),
        .o_count (w_count)
    );

    assign w_acc_add   = ((r_state == NEG) ? r_acc_n : r_acc_p) + ACC_W'(w_count);
    // Only meaningful on the last NEG cycle, where w_acc_add is the final negative count.
    assign w_sum_next  = {1'b0, r_acc_p} - {1'b0, w_acc_add};
    assign w_sum_ext   = {{(CMP_W-ACC_W-1){w_sum_next[ACC_W]}}, w_sum_next};
    assign w_thr_ext   = {{(CMP_W-THR_W){r_thr[THR_W-1]}}, r_thr};
    assign w_fire_next = ($signed(w_sum_ext) >= $signed(w_thr_ext));

`ifdef POPSEQ_ZERO_SKIP_EN
    logic [PAD_W-1:0] w_pos_in_pad;
    logic [NCH-1:0]   w_nz_cur, w_nz_in, w_nz_neg;

    assign w_pos_in_pad = PAD_W'(pos_mask);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_nz
            assign w_nz_cur[gi] = (r_state == NEG) ? |w_neg_ch[gi] : |w_pos_ch[gi];
            assign w_nz_in[gi]  = |w_pos_in_pad[gi*CHUNK_W +: CHUNK_W];
            assign w_nz_neg[gi] = |w_neg_ch[gi];
        end
    endgenerate

    // Priority encoders: lowest nonzero chunk above k, and first nonzero chunk of each phase.
    always_comb begin
        w_has_next  = 1'b0;
        w_k_next    = '0;
        w_first_pos = '0;
        w_first_neg = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (w_nz_cur[j] && (j > int'(r_k))) begin
                w_has_next = 1'b1;
                w_k_next   = K_W'(j);
            end
            if (w_nz_in[j]) begin
                w_first_pos = K_W'(j);
            end
            if (w_nz_neg[j]) begin
                w_first_neg = K_W'(j);
            end
        end
    end
`else
    assign w_has_next  = (r_k != K_LAST);
    assign w_k_next    = r_k + 1'b1;
    assign w_first_pos = '0;
    assign w_first_neg = '0;
`endif

    assign w_last = !w_has_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = POS;
            POS:     if (w_last)    w_state_next = NEG;
            NEG:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos   <= '0;
            r_neg   <= '0;
            r_thr   <= '0;
            r_acc_p <= '0;
            r_acc_n <= '0;
            r_k     <= '0;
            r_sum   <= '0;
            r_fire  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_pos   <= PAD_W'(pos_mask);
                        r_neg   <= PAD_W'(neg_mask);
                        r_thr   <= threshold;
                        r_acc_p <= '0;
                        r_acc_n <= '0;
                        r_k     <= w_first_pos;
                    end
                end
                POS: begin
                    r_acc_p <= w_acc_add;
                    r_k     <= w_last ? w_first_neg : w_k_next;
                end
                NEG: begin
                    r_acc_n <= w_acc_add;
                    r_k     <= w_last ? '0 : w_k_next;
                    if (w_last) begin
                        r_sum  <= w_sum_next;
                        r_fire <= w_fire_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign out_valid  = (r_state == DONE);
    assign sum        = r_sum;
    assign neuron_out = r_fire;

endmodule

// File: tb/tb_popcount_neuron_seq.sv
// Directed self-checking bench for popcount_neuron_seq (N_IN = 36, exact popcount).
module tb_popcount_neuron_seq;

    localparam int N_IN  = 36;
    localparam int THR_W = 8;
    localparam int ACC_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   pos_mask;
    logic [N_IN-1:0]   neg_mask;
    logic [THR_W-1:0]  threshold;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W:0]    sum;
    logic              neuron_out;
    logic              busy;

    int vectors    = 0;
    int miscompares = 0;

    popcount_neuron_seq #(
        .N_IN      (N_IN),
        .THR_W     (THR_W),
        .USE_EXACT (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pos_mask   (pos_mask),
        .neg_mask   (neg_mask),
        .threshold  (threshold),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .neuron_out (neuron_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the edge a request is first presented to the first out_valid sample.
    function automatic int exp_lat(input logic [N_IN-1:0] p, input logic [N_IN-1:0] n);
`ifdef POPSEQ_ZERO_SKIP_EN
        int cp = 0;
        int cn = 0;
        for (int i = 0; i < 4; i++) begin
            if (|p[i*9 +: 9]) cp++;
            if (|n[i*9 +: 9]) cn++;
        end
        return ((cp > 0) ? cp : 1) + ((cn > 0) ? cn : 1) + 1;
`else
        return 2 * 4 + 1;
`endif
    endfunction

    task automatic present(input logic [N_IN-1:0] p, input logic [N_IN-1:0] n,
                           input logic [THR_W-1:0] t);
        int w = 0;
        while (!in_ready && w < 100) begin
            step();
            w++;
        end
        check("in_ready_before_request", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        pos_mask  = p;
        neg_mask  = n;
        threshold = t;
        step();
        in_valid  = 1'b0;
        pos_mask  = ~p;
        neg_mask  = ~n;
        threshold = ~t;
        check("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check("out_valid_reached", 64'(out_valid), 64'd1);
    endtask

    task automatic run(input string tag, input logic [N_IN-1:0] p, input logic [N_IN-1:0] n,
                       input logic [THR_W-1:0] t, input logic [ACC_W:0] exp_sum,
                       input logic exp_fire);
        int lat;
        present(p, n, t);
        wait_done(lat);
        check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
        check({tag, "_fire"}, 64'(neuron_out), 64'(exp_fire));
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat(p, n)));
        check({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
        $display("txn %s: pos=%h neg=%h thr=%0d sum=%0d fire=%0b latency=%0d",
                 tag, p, n, $signed(t), $signed(sum), neuron_out, lat);
        step();
        check({tag, "_released"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        int lat;
        logic [ACC_W:0] held_sum;
        logic           held_fire;
        logic           saw_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pos_mask  = '0;
        neg_mask  = '0;
        threshold = '0;
        step();
        step();
        check("reset_in_ready",  64'(in_ready),   64'd1);
        check("reset_out_valid", 64'(out_valid),  64'd0);
        check("reset_busy",      64'(busy),       64'd0);
        check("reset_sum",       64'(sum),        64'd0);
        check("reset_fire",      64'(neuron_out), 64'd0);
        rst = 1'b0;
        step();

        run("all_pos",  36'hF_FFFF_FFFF, 36'h0,           8'd20,  7'h24, 1'b1);
        run("neg_wins", 36'h0_0000_01FF, 36'h0_0003_FFFF, 8'd0,   7'h77, 1'b0);
        run("eq_neg",   36'h0,           36'h0_0000_00FF, 8'hF8,  7'h78, 1'b1);
        run("below",    36'h0,           36'h0_0000_00FF, 8'hF9,  7'h78, 1'b0);

        // Back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        present(36'hA_AAAA_AAAA, 36'h0_0000_000F, 8'd14);
        wait_done(lat);
        check("hold_latency", 64'(lat), 64'(exp_lat(36'hA_AAAA_AAAA, 36'h0_0000_000F)));
        check("hold_sum", 64'(sum), 64'h0E);
        check("hold_fire", 64'(neuron_out), 64'd1);
        held_sum  = sum;
        held_fire = neuron_out;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_stable", 64'({out_valid, in_ready, neuron_out, sum}),
                  64'({1'b1, 1'b0, held_fire, held_sum}));
        end
        $display("txn hold: sum=%0d fire=%0b held 5 cycles", $signed(sum), neuron_out);
        // Request presented during the output handshake must wait for IDLE.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        pos_mask  = 36'h8_0000_0001;
        neg_mask  = 36'hF_0000_0000;
        threshold = 8'h80;
        step();
        check("b2b_idle_in_ready", 64'(in_ready), 64'd1);
        check("b2b_idle_busy", 64'(busy), 64'd0);
        step();
        in_valid = 1'b0;
        pos_mask = '0;
        neg_mask = '1;
        check("b2b_accepted", 64'(busy), 64'd1);
        wait_done(lat);
        check("b2b_latency", 64'(lat), 64'(exp_lat(36'h8_0000_0001, 36'hF_0000_0000)));
        check("b2b_sum", 64'(sum), 64'h7E);
        check("b2b_fire", 64'(neuron_out), 64'd1);
        $display("txn b2b: sum=%0d fire=%0b latency=%0d", $signed(sum), neuron_out, lat);
        step();

        // Reset on the second NEG cycle discards the transaction.
        present(36'hF_FFFF_FFFF, 36'h0_0000_0001, 8'd0);
        for (int i = 0; i < 5; i++) step();
        check("mid_neg_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        check("rst_no_pulse", 64'(saw_valid), 64'd0);
        $display("txn reset_mid_neg: aborted, no result");

        run("after_rst", 36'h1_2345_6789, 36'h0_0000_0003, 8'd13, 7'h0D, 1'b1);
`ifdef POPSEQ_ZERO_SKIP_EN
        run("zskip", 36'h1, 36'h0, 8'd1, 7'h01, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
